// File: rtl/sha_block_ctrl_if.sv
// Handshake bundle between the SHA-256 block sequencer and its neighbours
// (mining top level, message buffer, compression core, H registers).
interface sha_block_ctrl_if #(
    parameter int unsigned ROUNDS = 64
);
    localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    logic          start;
    logic          abort;
    logic          blk_ack;
    logic          blk_req;
    logic          blk_idx;
    logic          load_wv;
    logic          round_en;
    logic [RW-1:0] round;
    logic [1:0]    block;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, blk_ack,
        input  blk_req, blk_idx, load_wv, round_en, round, block, busy, done
    );

    modport slave (
        input  start, abort, blk_ack,
        output blk_req, blk_idx, load_wv, round_en, round, block, busy, done
    );
endinterface

// File: rtl/sha_block_ctrl.sv
// Sequencer for one SHA-256 hash over NUM_BLOCKS message blocks: requests each block,
// loads the working variables, issues ROUNDS round enables and drives the H-register block code.
module sha_block_ctrl #(
    parameter int unsigned ROUNDS     = 64,
    parameter int unsigned NUM_BLOCKS = 2
) (
    input logic              clk,
    input logic              rst_n,
    sha_block_ctrl_if.slave  bus
);
    localparam int unsigned   RW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] LastRound = RW'(ROUNDS - 1);
    localparam logic [1:0]    LastBlk   = 2'(NUM_BLOCKS);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StReq,
        StLoad,
        StRound,
        StAcc,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [1:0]    block_q, block_d;
    logic          blk_idx_q, blk_idx_d;
    logic [1:0]    blk_next;

    assign blk_next = {1'b0, blk_idx_q} + 2'd1;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        block_d   = block_q;
        blk_idx_d = blk_idx_q;
        // Abort outranks every other transition; IDLE has nothing to cancel.
        if (state_q != StIdle && bus.abort) begin
            state_d   = StIdle;
            round_d   = '0;
            block_d   = 2'd0;
            blk_idx_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        state_d   = StInit;
                        block_d   = 2'd0;
                        blk_idx_d = 1'b0;
                    end
                end
                StInit: state_d = StReq;
                StReq: begin
                    if (bus.blk_ack) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    state_d = StRound;
                    round_d = '0;
                end
                StRound: begin
                    if (round_q == LastRound) begin
                        state_d = StAcc;
                        block_d = blk_next;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end
                StAcc: begin
                    if (blk_next == LastBlk) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StReq;
                        blk_idx_d = blk_next[0];
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            round_q   <= '0;
            block_q   <= 2'd0;
            blk_idx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            block_q   <= block_d;
            blk_idx_q <= blk_idx_d;
        end
    end

    assign bus.blk_req  = (state_q == StReq);
    assign bus.load_wv  = (state_q == StLoad);
    assign bus.round_en = (state_q == StRound);
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.round    = round_q;
    assign bus.block    = block_q;
    assign bus.blk_idx  = blk_idx_q;
endmodule

// File: tb/tb_sha_block_ctrl.sv
// Scoreboard bench for sha_block_ctrl: a timeline model predicts block-code changes, done cycles
// and handshake run lengths; a negedge monitor pops and compares as the DUT produces them.
module tb_sha_block_ctrl;
    localparam int unsigned ROUNDS = 64;

    typedef struct {int cyc; int val;}       ev_t;
    typedef struct {int len; int idx;}       req_t;
    typedef struct {int len; int end_round;} rnd_t;
    typedef struct {int len; int loads;}     busy_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_block = 0;

    ev_t   blk_q[$];
    int    done_q[$];
    req_t  req_q[$];
    rnd_t  rnd_q[$];
    busy_t busy_q[$];

    // Monitor-only state.
    int    blk_prev, busy_len, load_cnt, req_len, req_idx, rnd_len;
    bit    busy_prev, req_prev, rnd_prev;
    ev_t   e_tmp;
    req_t  r_tmp;
    rnd_t  d_tmp;
    busy_t b_tmp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha_block_ctrl_if #(.ROUNDS(ROUNDS)) bus ();
    sha_block_ctrl_if #(.ROUNDS(ROUNDS)) bus1 ();

    sha_block_ctrl #(.ROUNDS(ROUNDS), .NUM_BLOCKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sha_block_ctrl #(.ROUNDS(ROUNDS), .NUM_BLOCKS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int outs0();
        return int'({bus.blk_req, bus.blk_idx, bus.load_wv, bus.round_en, bus.round, bus.block,
                     bus.busy, bus.done});
    endfunction

    function automatic int outs1();
        return int'({bus1.blk_req, bus1.blk_idx, bus1.load_wv, bus1.round_en, bus1.round,
                     bus1.block, bus1.busy, bus1.done});
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            blk_q.delete();
            done_q.delete();
            req_q.delete();
            rnd_q.delete();
            busy_q.delete();
            blk_prev  = 0;
            busy_prev = 0;
            req_prev  = 0;
            rnd_prev  = 0;
            busy_len  = 0;
            load_cnt  = 0;
            req_len   = 0;
            rnd_len   = 0;
        end else begin
            if (int'(bus.block) != blk_prev) begin
                if (blk_q.size() == 0) begin
                    check("block_unexpected_change", int'(bus.block), blk_prev);
                end else begin
                    e_tmp = blk_q.pop_front();
                    check("block_change_cycle", cyc, e_tmp.cyc);
                    check("block_change_value", int'(bus.block), e_tmp.val);
                end
                blk_prev = int'(bus.block);
            end

            if (bus.done) begin
                if (done_q.size() == 0) check("done_unexpected", int'(bus.done), 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end

            if (bus.busy && !busy_prev) begin
                check("busy_rise_expected", int'(busy_q.size() > 0), 1);
                busy_len = 0;
                load_cnt = 0;
            end
            if (bus.busy) begin
                busy_len++;
                load_cnt += int'(bus.load_wv);
            end else if (busy_prev && busy_q.size() > 0) begin
                b_tmp = busy_q.pop_front();
                check("busy_length", busy_len, b_tmp.len);
                check("load_wv_pulses", load_cnt, b_tmp.loads);
            end
            busy_prev = bus.busy;

            if (bus.blk_req) begin
                if (!req_prev) begin
                    req_len = 0;
                    req_idx = int'(bus.blk_idx);
                end
                req_len++;
            end else if (req_prev) begin
                if (req_q.size() == 0) begin
                    check("blk_req_unexpected_run", req_len, 0);
                end else begin
                    r_tmp = req_q.pop_front();
                    check("blk_req_length", req_len, r_tmp.len);
                    check("blk_idx_in_req", req_idx, r_tmp.idx);
                end
            end
            req_prev = bus.blk_req;

            if (bus.round_en) begin
                if (!rnd_prev) rnd_len = 0;
                check("round_index", int'(bus.round), rnd_len);
                rnd_len++;
            end else if (rnd_prev) begin
                if (rnd_q.size() == 0) begin
                    check("round_en_unexpected_run", rnd_len, 0);
                end else begin
                    d_tmp = rnd_q.pop_front();
                    check("round_en_length", rnd_len, d_tmp.len);
                    check("round_after_run", int'(bus.round), d_tmp.end_round);
                end
            end
            rnd_prev = bus.round_en;
        end
    end

    // ab: 0 none, -1 abort in DONE, >0 abort at that cycle offset (block 1 ROUND).
    // rst_round: -1 none, else async reset during that round of block 0.
    task automatic run_hash(input int s0, input int s1, input int ab_in, input bit abuse,
                            input int rst_round);
        int   cs, req0, acc0, req1, rs1, acc1, done_off, ab, last, rst_off;
        ev_t  e;
        req_t r;
        rnd_t d;
        busy_t b;
        req0     = 2;
        acc0     = req0 + s0 + 2 + ROUNDS;
        req1     = acc0 + 1;
        rs1      = req1 + s1 + 2;
        acc1     = rs1 + ROUNDS;
        done_off = acc1 + 1;
        ab       = (ab_in < 0) ? done_off : ab_in;
        rst_off  = (rst_round >= 0) ? req0 + s0 + 2 + rst_round : 0;
        last     = (ab > 0) ? ab : done_off;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.blk_ack = 1'b0;
        @(posedge clk);
        #1;
        cs = cyc;  // offset k is observed at the negedge where cyc == cs + k - 1

        if (model_block != 0) begin
            e = '{cyc: cs, val: 0};
            blk_q.push_back(e);
        end
        e = '{cyc: cs + acc0 - 1, val: 1};
        blk_q.push_back(e);
        if (ab == 0 || ab == done_off) begin
            e = '{cyc: cs + acc1 - 1, val: 2};
            blk_q.push_back(e);
            done_q.push_back(cs + done_off - 1);
        end
        if (ab > 0) begin
            e = '{cyc: cs + ab, val: 0};
            blk_q.push_back(e);
        end
        r = '{len: s0 + 1, idx: 0};
        req_q.push_back(r);
        r = '{len: s1 + 1, idx: 1};
        req_q.push_back(r);
        d = '{len: ROUNDS, end_round: ROUNDS - 1};
        rnd_q.push_back(d);
        if (ab > 0 && ab < done_off) d = '{len: ab - rs1 + 1, end_round: 0};
        rnd_q.push_back(d);
        b = '{len: last, loads: 2};
        busy_q.push_back(b);
        model_block = (ab > 0) ? 0 : 2;

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            bus.start = abuse && ($urandom_range(0, 3) == 0);
            bus.abort = (k == ab);
            if (k >= req0 && k <= req0 + s0) bus.blk_ack = (k == req0 + s0);
            else if (k >= req1 && k <= req1 + s1) bus.blk_ack = (k == req1 + s1);
            else bus.blk_ack = abuse && ($urandom_range(0, 1) == 1);
            if (k == rst_off) begin
                bus.start   = 1'b0;
                bus.abort   = 1'b0;
                bus.blk_ack = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("async_reset_outputs", outs0(), 0);
                model_block = 0;
                break;
            end
        end
        if (rst_off > 0) begin
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.blk_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic single_block();
        int done_k, done_n, loads, rens;
        done_k = 0;
        done_n = 0;
        loads  = 0;
        rens   = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) bus1.start = 1'b0;
            if (bus1.done) begin
                done_k = k;
                done_n++;
            end
            loads += int'(bus1.load_wv);
            rens  += int'(bus1.round_en);
        end
        check("single_done_offset", done_k, 69);
        check("single_done_count", done_n, 1);
        check("single_load_count", loads, 1);
        check("single_round_en_cycles", rens, ROUNDS);
        check("single_final_block", int'(bus1.block), 1);
        check("single_idle_after", int'(bus1.busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.blk_ack  = 1'b0;
        bus1.start   = 1'b0;
        bus1.abort   = 1'b0;
        bus1.blk_ack = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs0(), 0);
        check("reset_outputs_single", outs1(), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_hash(0, 0, 0, 1'b0, -1);          // nominal
        run_hash(5, 5, 0, 1'b0, -1);          // ack stall
        run_hash(0, 0, 0, 1'b1, -1);          // protocol abuse
        single_block();
        run_hash(0, 0, 2 + 2 + ROUNDS + 1 + 2 + 30, 1'b0, -1);  // abort at block 1 round 30
        run_hash(0, 0, 0, 1'b0, -1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_start_abort_busy", int'(bus.busy), 0);
        check("idle_start_abort_block", int'(bus.block), model_block);
        repeat (3) @(negedge clk);

        run_hash(2, 1, -1, 1'b0, -1);         // abort in DONE
        run_hash($urandom_range(0, 3), 0, 0, 1'b0, 10);  // async reset at block 0 round 10
        run_hash(0, 0, 0, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run_hash($urandom_range(0, 4), $urandom_range(0, 4), 0, 1'($urandom_range(0, 1)), -1);
        end

        repeat (5) @(negedge clk);
        check("drain_block_events", blk_q.size(), 0);
        check("drain_done_events", done_q.size(), 0);
        check("drain_req_runs", req_q.size(), 0);
        check("drain_round_runs", rnd_q.size(), 0);
        check("drain_busy_runs", busy_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
